// File: rtl/sprite_line_engine.sv
// Per-scanline sprite evaluator: scans the sprite table during hblank into line slots, then picks the winning sprite per pixel.
// Latency: a scan takes NUM_SPRITES+1 cycles from line_start; pixel outputs are registered with 1 cycle of latency.
// Backpressure: none; line_start restarts the scan at any time, and the table must be held stable while a scan runs.
module sprite_line_engine #(
    parameter int NUM_SPRITES = 8,
    parameter int SLOTS       = 4,
    parameter int XW          = 12,
    parameter int YW          = 11,
    parameter int ATTR_W      = 8,
    parameter int SPR_W       = 64,
    parameter int SPR_H       = 64
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NUM_SPRITES*(1+XW+YW+ATTR_W)-1:0]   sprite_table,
    input  logic                                      line_start,
    input  logic [YW-1:0]                             next_y,
    input  logic [XW-1:0]                             display_x,
    input  logic                                      active,
    output logic                                      hit,
    output logic [ATTR_W-1:0]                         hit_attr,
    output logic [$clog2(SPR_W)-1:0]                  rel_x,
    output logic [$clog2(SPR_H)-1:0]                  rel_y,
    output logic                                      overflow,
    output logic                                      eval_busy
);
    localparam int ENTRY_W = 1 + XW + YW + ATTR_W;
    localparam int RXW     = $clog2(SPR_W);
    localparam int RYW     = $clog2(SPR_H);
    localparam int IDXW    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int FW      = $clog2(SLOTS + 1);

    typedef enum logic [1:0] {IDLE, SCAN, SWAP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IDXW-1:0]     r_idx;
    logic [FW-1:0]       r_fill;
    logic [YW-1:0]       r_ly;
    logic                r_povf;
    logic                r_ovf;

    // Evaluation bank (filled during the scan) and display bank (read by the pixel stage).
    logic                r_ev_vld  [SLOTS];
    logic [XW-1:0]       r_ev_x    [SLOTS];
    logic [ATTR_W-1:0]   r_ev_attr [SLOTS];
    logic [RYW-1:0]      r_ev_row  [SLOTS];
    logic                r_dp_vld  [SLOTS];
    logic [XW-1:0]       r_dp_x    [SLOTS];
    logic [ATTR_W-1:0]   r_dp_attr [SLOTS];
    logic [RYW-1:0]      r_dp_row  [SLOTS];

    logic [ENTRY_W-1:0]  w_entry;
    logic                w_en;
    logic [XW-1:0]       w_ex;
    logic [YW-1:0]       w_ey;
    logic [ATTR_W-1:0]   w_ea;
    logic [YW:0]         w_dy;
    logic                w_match;
    logic                w_last;

    logic                w_hit;
    logic [ATTR_W-1:0]   w_attr;
    logic [RXW-1:0]      w_rx;
    logic [RYW-1:0]      w_ry;
    logic [XW:0]         w_dx;

    // Select the table entry addressed by the scan index.
    always_comb begin
        w_entry = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_entry = sprite_table[i*ENTRY_W +: ENTRY_W];
            end
        end
    end

    assign w_en    = w_entry[ENTRY_W-1];
    assign w_ex    = w_entry[ENTRY_W-2 -: XW];
    assign w_ey    = w_entry[YW+ATTR_W-1 -: YW];
    assign w_ea    = w_entry[ATTR_W-1:0];
    // One extra bit keeps a sprite below the line from wrapping into a false match.
    assign w_dy    = {1'b0, r_ly} - {1'b0, w_ey};
    assign w_match = w_en && !w_dy[YW] && (w_dy < (YW+1)'(SPR_H));
    assign w_last  = (r_idx == IDXW'(NUM_SPRITES - 1));

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; line_start restarts the scan from any state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = IDLE;
            SCAN:    if (w_last) w_next = SWAP;
            SWAP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (line_start) begin
            w_next = SCAN;
        end
    end

    assign eval_busy = (r_state == SCAN);
    assign overflow  = r_ovf;

    // Scan datapath: slot loading, overflow tracking and the bank swap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx  <= '0;
            r_fill <= '0;
            r_ly   <= '0;
            r_povf <= 1'b0;
            r_ovf  <= 1'b0;
            for (int s = 0; s < SLOTS; s++) begin
                r_ev_vld[s]  <= 1'b0;
                r_ev_x[s]    <= '0;
                r_ev_attr[s] <= '0;
                r_ev_row[s]  <= '0;
                r_dp_vld[s]  <= 1'b0;
                r_dp_x[s]    <= '0;
                r_dp_attr[s] <= '0;
                r_dp_row[s]  <= '0;
            end
        end else begin
            // The copy reads the old evaluation bank, so it survives a same-cycle line_start.
            if (r_state == SWAP) begin
                r_ovf <= r_povf;
                for (int s = 0; s < SLOTS; s++) begin
                    r_dp_vld[s]  <= r_ev_vld[s];
                    r_dp_x[s]    <= r_ev_x[s];
                    r_dp_attr[s] <= r_ev_attr[s];
                    r_dp_row[s]  <= r_ev_row[s];
                end
            end
            if (line_start) begin
                r_ly   <= next_y;
                r_idx  <= '0;
                r_fill <= '0;
                r_povf <= 1'b0;
                for (int s = 0; s < SLOTS; s++) begin
                    r_ev_vld[s] <= 1'b0;
                end
            end else if (r_state == SCAN) begin
                if (w_match) begin
                    if (r_fill < FW'(SLOTS)) begin
                        for (int s = 0; s < SLOTS; s++) begin
                            if (r_fill == FW'(s)) begin
                                r_ev_vld[s]  <= 1'b1;
                                r_ev_x[s]    <= w_ex;
                                r_ev_attr[s] <= w_ea;
                                r_ev_row[s]  <= w_dy[RYW-1:0];
                            end
                        end
                        r_fill <= r_fill + 1'b1;
                    end else begin
                        r_povf <= 1'b1;
                    end
                end
                if (!w_last) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    // Pixel selection: walk slots from highest to lowest so the lowest hitting slot wins.
    always_comb begin
        w_hit  = 1'b0;
        w_attr = '0;
        w_rx   = '0;
        w_ry   = '0;
        w_dx   = '0;
        if (active) begin
            for (int s = SLOTS - 1; s >= 0; s--) begin
                w_dx = {1'b0, display_x} - {1'b0, r_dp_x[s]};
                if (r_dp_vld[s] && !w_dx[XW] && (w_dx < (XW+1)'(SPR_W))) begin
                    w_hit  = 1'b1;
                    w_attr = r_dp_attr[s];
                    w_rx   = r_dp_attr[s][ATTR_W-1] ? (RXW'(SPR_W - 1) - w_dx[RXW-1:0])
                                                    : w_dx[RXW-1:0];
                    w_ry   = r_dp_row[s];
                end
            end
        end
    end

    // Pixel output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit      <= 1'b0;
            hit_attr <= '0;
            rel_x    <= '0;
            rel_y    <= '0;
        end else begin
            hit      <= w_hit;
            hit_attr <= w_attr;
            rel_x    <= w_rx;
            rel_y    <= w_ry;
        end
    end
endmodule

// File: doc/sprite_line_engine.md
# sprite_line_engine

Parametrised per-scanline sprite evaluator and pixel selector. It sits between the game state machine's sprite table and the colour-table lookup in the PPU, and replaces the fixed two-sprite comparator. During horizontal blanking it scans up to NUM_SPRITES table entries and loads the ones that intersect the next line into SLOTS double-buffered line slots. During the visible part of the line it reports, per pixel, the highest-priority sprite hit with its pattern-relative coordinates.

## Interface
Parameters:
- NUM_SPRITES, 8, sprite table entries scanned per line (≥1)
- SLOTS, 4, sprites displayable per line (1..NUM_SPRITES)
- XW, 12, screen x width
- YW, 11, screen y width
- ATTR_W, 8, attribute width; attr[ATTR_W-1] = horizontal mirror
- SPR_W, 64, sprite width in pixels
- SPR_H, 64, sprite height in pixels

Entry layout, ENTRY_W = 1+XW+YW+ATTR_W, MSB first: {en, x, y, attr}. x and y are the top-left screen coordinates.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- sprite_table  in  NUM_SPRITES*ENTRY_W  flat table, entry i at [i*ENTRY_W +: ENTRY_W]
- line_start  in  1  one-cycle pulse at start of hblank
- next_y  in  YW  line to evaluate, valid with line_start
- display_x  in  XW  current pixel column
- active  in  1  visible-area flag
- hit  out  1  a sprite covers this pixel
- hit_attr  out  ATTR_W  attribute of the winning sprite
- rel_x  out  clog2(SPR_W)  column within the pattern, mirror applied
- rel_y  out  clog2(SPR_H)  row within the pattern
- overflow  out  1  more than SLOTS sprites matched the last completed line
- eval_busy  out  1  scan in progress

## Operation
- FSM states: IDLE, SCAN, SWAP.
- line_start in any state:
  - latch next_y into ly.
  - Clear the evaluation bank and the pending-overflow bit.
  - Set idx=0 and enter SCAN.
- SCAN, one entry per cycle, entry idx:
  - Match when en=1, ly ≥ y and (ly − y) < SPR_H.
  - Compare in YW+1 bits so the result never wraps.
  - On a match with fill < SLOTS: write {x, attr, ly−y} to slot[fill] and increment fill.
  - On a match with fill = SLOTS: set pending-overflow and do not write a slot.
  - When idx = NUM_SPRITES−1, go to SWAP. Otherwise increment idx.
- SWAP, one cycle:
  - Copy the evaluation bank (valid bits included) into the display bank.
  - Copy pending-overflow into overflow.
  - Go to IDLE.
- line_start during SCAN aborts the scan. No copy takes place, and the display bank and overflow keep their values.
- Pixel stage, evaluated every cycle against the display bank:
  - Slot s hits when valid, display_x ≥ x_s and (display_x − x_s) < SPR_W.
  - The lowest slot index wins, which is the same as the lowest table index.
  - rel_x = d or SPR_W−1−d when the mirror bit is set, where d = display_x − x_s.
  - rel_y is the stored row.
- When active=0 or no slot hits: hit=0, and hit_attr, rel_x and rel_y are 0.
- The sprite_table is sampled live during SCAN. The producer holds it stable during hblank.

## Timing
- Reset values:
  - All outputs 0.
  - Both banks invalid.
  - FSM in IDLE, idx=0, fill=0.
- Scan schedule:
  - line_start sampled at edge t.
  - Entry i is evaluated in the cycle after edge t+i.
  - SWAP occupies the cycle after edge t+NUM_SPRITES.
  - The new display bank is visible from edge t+NUM_SPRITES+1.
  - hblank must be at least NUM_SPRITES+2 cycles.
- eval_busy is 1 while in SCAN and 0 in IDLE and SWAP.
- Pixel outputs are registered with a latency of 1 cycle: inputs at edge k produce outputs after edge k+1.
- line_start in SWAP: the copy completes that cycle and SCAN starts on the same edge with cleared evaluation state.
- Reset mid-scan clears everything asynchronously. The next line shows no sprites until a full scan completes.

## Test plan
- Single sprite: entry0 = {1, x=100, y=50, attr=0x05}, line_start with next_y=60 -> after NUM_SPRITES+1 cycles, display_x=100 gives hit=1, rel_x=0, rel_y=10, attr=0x05; display_x=163 gives rel_x=63; display_x=164 gives hit=0.
- Mirror: attr=0x85, display_x=100 -> rel_x=63.
- Priority: entries 2 and 5 overlap at x=200 on the line -> hit_attr comes from entry 2. Disable entry 2 -> entry 5 wins.
- Overflow: 6 matching entries with SLOTS=4 -> entries 0..3 displayed, entry 4 never hits, overflow=1. Next line with 1 match -> overflow=0 after SWAP.
- Abort: line_start at scan cycle 3, then a full scan -> display bank changes only once, at the end of the second scan. eval_busy stays high continuously.
- Reset: assert reset mid-visible with hit=1 -> hit=0 immediately. Boundary next_y = y+SPR_H gives no match. A sprite at y > next_y gives no match (no wrap).
